// File: rtl/misr_signature_unit_if.sv
// rtl/misr_signature_unit_if.sv - control/data bundle between test controller and MISR signature unit
interface misr_signature_unit_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             start;
    logic             abort;
    logic [1:0]       mode;
    logic             seed_load;
    logic [WIDTH-1:0] seed;
    logic             data_valid;
    logic [WIDTH-1:0] data_in;
    logic [CNT_W-1:0] length;
    logic [WIDTH-1:0] expected;
    logic [WIDTH-1:0] signature;
    logic             busy;
    logic             done;
    logic             pass;
    logic             fail;

    modport master (
        output start, abort, mode, seed_load, seed, data_valid, data_in, length, expected,
        input  signature, busy, done, pass, fail
    );

    modport slave (
        input  start, abort, mode, seed_load, seed, data_valid, data_in, length, expected,
        output signature, busy, done, pass, fail
    );
endinterface

// File: rtl/misr_signature_unit.sv
// rtl/misr_signature_unit.sv - parametrised MISR/LFSR signature register with bounded run and golden compare
module misr_signature_unit #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] POLY  = 32'h00010811,
    parameter int               CNT_W = 16
) (
    input  logic                  CLK,
    input  logic                  RESET,
    misr_signature_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sig_q, sig_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             step_en;
    logic [WIDTH-1:0] step_data;

    // Bit 0 takes the feedback unconditionally; POLY[0] only documents the +1 term.
    function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] s,
                                                   input logic [WIDTH-1:0] d);
        logic             fb;
        logic [WIDTH-1:0] n;
        fb   = s[WIDTH-1];
        n    = '0;
        n[0] = fb ^ d[0];
        for (int i = 1; i < WIDTH; i++) begin
            n[i] = s[i-1] ^ (POLY[i] & fb) ^ d[i];
        end
        return n;
    endfunction

    always_comb begin
        step_en   = 1'b0;
        step_data = '0;
        case (bus.mode)
            2'd0: begin
                step_en   = bus.data_valid;
                step_data = bus.data_in;
            end
            2'd1:    step_en = 1'b1;
            default: step_en = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        exp_d   = exp_q;
        cnt_d   = cnt_q;
        len_d   = len_q;

        if (bus.abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.seed_load) begin
                        sig_d   = bus.seed;
                        state_d = ST_IDLE;
                    end
                    // A zero-length run completes without stepping, so the compare operand is captured now.
                    if (bus.start) begin
                        len_d = bus.length;
                        cnt_d = '0;
                        if (bus.length == '0) begin
                            state_d = ST_DONE;
                            exp_d   = bus.expected;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (step_en) begin
                        sig_d = misr_step(sig_q, step_data);
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_d == len_q) begin
                            state_d = ST_DONE;
                            exp_d   = bus.expected;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            sig_q   <= '0;
            exp_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            exp_q   <= exp_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.signature = sig_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = done_q & (sig_q == exp_q);
    assign bus.fail      = done_q & (sig_q != exp_q);

endmodule
